// File: rtl/glb_opsum_checker.sv
// glb_opsum_checker
//   Walks a strided opsum region of the GLB after the PE array finishes and
//   compares every word against a golden stream. Reports a saturating error
//   count, the first mismatch (address, GLB value, golden value) and a
//   pass flag that holds until the next run starts.
//
// Handshake: gold_data is consumed on a rising edge where gold_valid and
//   gold_ready are both high; gold_ready is high only while a GLB word is
//   waiting to be compared, and gold_valid may drop at any time to stall.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             one-cycle pulse, latches config and begins a run
//   base_addr/stride  byte address of first word / byte step per word
//   num_words         number of words to check (0 finishes immediately)
//   mode/tol          0 = exact, 1 = |signed diff| <= tol accepted
//   glb_rd_*          GLB read port, data returned one cycle after rd_en
//   gold_*            golden stream, valid/ready
//   busy/done/pass    run status; done is a one-cycle pulse
//   err_count         mismatches in the last run (saturating)
//   first_err_*       address / GLB value / golden value of first mismatch
//   dbg_state         current FSM state for checkers and debug
module glb_opsum_checker #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              mode,
    input  logic [DATA_W-1:0] tol,
    output logic              glb_rd_en,
    output logic [ADDR_W-1:0] glb_rd_addr,
    input  logic [DATA_W-1:0] glb_rd_data,
    input  logic              gold_valid,
    input  logic [DATA_W-1:0] gold_data,
    output logic              gold_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_got,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_CMP   = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    state_t            state_nx;

    logic [ADDR_W-1:0] cfg_stride;
    logic              cfg_mode;
    logic [DATA_W-1:0] cfg_tol;
    logic [ADDR_W-1:0] addr_reg;
    logic [CNT_W-1:0]  remaining;
    logic [DATA_W-1:0] got_reg;

    logic signed [DATA_W:0] diff;
    logic        [DATA_W:0] diff_mag;
    logic                   mismatch;

    // Sign-extend both operands by one bit so the subtraction cannot
    // overflow; the magnitude then always fits in DATA_W+1 bits.
    always_comb begin
        diff     = $signed({got_reg[DATA_W-1], got_reg}) - $signed({gold_data[DATA_W-1], gold_data});
        diff_mag = diff[DATA_W] ? DATA_W'(0) - diff : diff;
        diff_mag = diff[DATA_W] ? $unsigned(-diff) : $unsigned(diff);
        if (cfg_mode)
            mismatch = diff_mag > {1'b0, cfg_tol};
        else
            mismatch = got_reg != gold_data;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nx = (num_words == '0) ? S_FIN : S_FETCH;
            end
            S_FETCH: state_nx = S_WAIT;
            S_WAIT:  state_nx = S_CMP;
            S_CMP: begin
                if (gold_valid)
                    state_nx = (remaining == CNT_W'(1)) ? S_FIN : S_FETCH;
            end
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        glb_rd_en   = (state == S_FETCH);
        glb_rd_addr = (state == S_FETCH) ? addr_reg : '0;
        gold_ready  = (state == S_CMP);
        dbg_state   = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cfg_stride     <= '0;
            cfg_mode       <= 1'b0;
            cfg_tol        <= '0;
            addr_reg       <= '0;
            remaining      <= '0;
            got_reg        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_got  <= '0;
            first_err_exp  <= '0;
        end else begin
            state <= state_nx;
            // done is registered so it lands in the cycle after FIN,
            // together with busy falling and pass becoming valid.
            done  <= (state == S_FIN);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cfg_stride     <= stride;
                        cfg_mode       <= mode;
                        cfg_tol        <= tol;
                        addr_reg       <= base_addr;
                        remaining      <= num_words;
                        busy           <= 1'b1;
                        pass           <= 1'b0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        first_err_got  <= '0;
                        first_err_exp  <= '0;
                    end
                end
                S_WAIT: got_reg <= glb_rd_data;
                S_CMP: begin
                    if (gold_valid) begin
                        if (mismatch) begin
                            if (err_count != CNT_MAX)
                                err_count <= err_count + CNT_W'(1);
                            // Saturation never returns the count to zero,
                            // so zero reliably means no mismatch yet.
                            if (err_count == '0) begin
                                first_err_addr <= addr_reg;
                                first_err_got  <= got_reg;
                                first_err_exp  <= gold_data;
                            end
                        end
                        addr_reg  <= addr_reg + cfg_stride;
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                S_FIN: begin
                    busy <= 1'b0;
                    pass <= (err_count == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_glb_opsum_checker.sv
module tb_glb_opsum_checker;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] stride;
  logic [CW-1:0] num_words;
  logic          mode;
  logic [DW-1:0] tol;
  logic          glb_rd_en;
  logic [AW-1:0] glb_rd_addr;
  logic [DW-1:0] glb_rd_data;
  logic          gold_valid;
  logic [DW-1:0] gold_data;
  logic          gold_ready;
  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] err_count;
  logic [AW-1:0] first_err_addr;
  logic [DW-1:0] first_err_got;
  logic [DW-1:0] first_err_exp;
  logic [2:0]    dbg_state;

  glb_opsum_checker #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
    .num_words(num_words), .mode(mode), .tol(tol), .glb_rd_en(glb_rd_en),
    .glb_rd_addr(glb_rd_addr), .glb_rd_data(glb_rd_data), .gold_valid(gold_valid),
    .gold_data(gold_data), .gold_ready(gold_ready), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr),
    .first_err_got(first_err_got), .first_err_exp(first_err_exp), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- GLB model ----------------
  logic [DW-1:0] glb_mem [int];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (glb_mem.exists(int'(a))) return glb_mem[int'(a)];
    return 32'hC0DE_0000 | {16'h0, a};
  endfunction

  // ---------------- monitors / golden driver ----------------
  logic [AW-1:0] rd_addr_q[$];
  logic [DW-1:0] gold_q[$];
  logic [DW-1:0] gold_src[$];
  int  consumed     = 0;
  int  done_cnt     = 0;
  bit  overlap_seen = 0;
  bit  consume_flag = 0;
  bit  stall_mode   = 0;
  int  gcyc         = 0;

  // Sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (glb_rd_en) begin
      rd_addr_q.push_back(glb_rd_addr);
      glb_rd_data = mem_word(glb_rd_addr);
    end
    if (glb_rd_en && gold_ready) overlap_seen = 1;
    if (done) done_cnt++;
    if (gold_valid && gold_ready) consume_flag = 1;
  end

  always begin
    @(posedge clk);
    #1;
    if (consume_flag) begin
      if (gold_q.size() > 0) void'(gold_q.pop_front());
      consumed++;
      consume_flag = 0;
    end
    gcyc++;
    gold_valid = (gold_q.size() > 0) && (!stall_mode || (gcyc % 3 == 0));
    gold_data  = (gold_q.size() > 0) ? gold_q[0] : '0;
  end

  // ---------------- generic run with reference model ----------------
  task automatic run_check(input string name, input logic [AW-1:0] b, input logic [AW-1:0] s,
                           input int n, input logic m, input logic [DW-1:0] t,
                           input int exp_lat, input int glitch_at);
    logic [AW-1:0] exp_q[$];
    int            exp_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_got, e_exp;
    int            cycles;
    int            done_before;
    bit            seq_ok;
    exp_err = 0; e_addr = '0; e_got = '0; e_exp = '0;
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] g, x;
      longint        d;
      bit            bad;
      a = AW'(int'(b) + i * int'(s));
      g = mem_word(a);
      x = gold_src[i];
      exp_q.push_back(a);
      d = longint'($signed(g)) - longint'($signed(x));
      if (d < 0) d = -d;
      bad = m ? (d > longint'(t)) : (g != x);
      if (bad) begin
        if (exp_err == 0) begin e_addr = a; e_got = g; e_exp = x; end
        if (exp_err < 65535) exp_err++;
      end
    end

    rd_addr_q.delete();
    gold_q = gold_src;
    consumed = 0;
    overlap_seen = 0;
    done_before = done_cnt;

    @(posedge clk); #1;
    base_addr = b; stride = s; num_words = CW'(n); mode = m; tol = t; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 16'($urandom); stride = 16'($urandom); num_words = 16'($urandom);
    mode = ~m; tol = $urandom;
    cycles = 1;
    while (1) begin
      @(negedge clk);
      if (glitch_at > 0 && cycles == glitch_at) begin
        start = 1'b1; base_addr = 16'h0000; stride = 16'h0; num_words = 16'd1;
      end else if (glitch_at > 0 && cycles == glitch_at + 1) begin
        start = 1'b0;
      end
      if (done || cycles > 2000) break;
      cycles++;
    end

    n_vec++;
    if (!done) begin
      n_err++; $display("FAIL %s done_timeout: got none required pulse", name);
    end
    if (exp_lat >= 0) begin
      n_vec++;
      if (cycles !== exp_lat) begin n_err++; $display("FAIL %s latency: got %0d required %0d", name, cycles, exp_lat); end
    end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy_at_done: got %b required 0", name, busy); end
    n_vec++;
    if (err_count !== CW'(exp_err)) begin n_err++; $display("FAIL %s err_count: got %0d required %0d", name, err_count, exp_err); end
    n_vec++;
    if (pass !== (exp_err == 0)) begin n_err++; $display("FAIL %s pass: got %b required %b", name, pass, exp_err == 0); end
    n_vec++;
    if (first_err_addr !== e_addr || first_err_got !== e_got || first_err_exp !== e_exp) begin
      n_err++;
      $display("FAIL %s first_err: got %h/%h/%h required %h/%h/%h", name,
               first_err_addr, first_err_got, first_err_exp, e_addr, e_got, e_exp);
    end
    seq_ok = (rd_addr_q.size() == exp_q.size());
    if (seq_ok) foreach (exp_q[i]) if (rd_addr_q[i] !== exp_q[i]) seq_ok = 0;
    n_vec++;
    if (!seq_ok) begin n_err++; $display("FAIL %s rd_addr_seq: got %p required %p", name, rd_addr_q, exp_q); end
    n_vec++;
    if (consumed !== n) begin n_err++; $display("FAIL %s gold_consumed: got %0d required %0d", name, consumed, n); end
    n_vec++;
    if (overlap_seen) begin n_err++; $display("FAIL %s rd_en_ready_overlap: got 1 required 0", name); end

    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (done_cnt - done_before !== 1) begin n_err++; $display("FAIL %s done_pulses: got %0d required 1", name, done_cnt - done_before); end
    n_vec++;
    if (err_count !== CW'(exp_err) || pass !== (exp_err == 0)) begin
      n_err++; $display("FAIL %s held_result: got %0d/%b required %0d/%b", name, err_count, pass, exp_err, exp_err == 0);
    end
  endtask

  task automatic load_gold_equal(input logic [AW-1:0] b, input logic [AW-1:0] s, input int n);
    gold_src.delete();
    for (int i = 0; i < n; i++) gold_src.push_back(mem_word(AW'(int'(b) + i * int'(s))));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 0 || done !== 0 || pass !== 0) begin
      n_err++; $display("FAIL reset_status: got busy=%b done=%b pass=%b required 0/0/0", busy, done, pass);
    end
    n_vec++;
    if (err_count !== '0 || first_err_addr !== '0 || first_err_got !== '0 || first_err_exp !== '0) begin
      n_err++; $display("FAIL reset_results: got %h/%h/%h/%h required all 0", err_count, first_err_addr, first_err_got, first_err_exp);
    end
    n_vec++;
    if (glb_rd_en !== 0 || gold_ready !== 0 || glb_rd_addr !== '0 || dbg_state !== 3'd0) begin
      n_err++; $display("FAIL reset_port: got rd_en=%b ready=%b addr=%h st=%0d required 0", glb_rd_en, gold_ready, glb_rd_addr, dbg_state);
    end
    rst = 1'b0;
  endtask

  task automatic test_exact_pass();
    load_gold_equal(16'h0100, 16'd4, 8);
    run_check("exact_pass", 16'h0100, 16'd4, 8, 1'b0, 32'd0, 26, 0);
  endtask

  task automatic test_exact_mismatch();
    glb_mem[int'(16'h010C)] = 32'h0000_0010;
    load_gold_equal(16'h0100, 16'd4, 8);
    gold_src[3] = 32'h0000_0011;
    run_check("exact_mismatch", 16'h0100, 16'd4, 8, 1'b0, 32'd0, 26, 0);
  endtask

  task automatic test_tolerance();
    glb_mem[int'(16'h0200)] = 32'hFFFF_FFFE;
    gold_src.delete(); gold_src.push_back(32'h0000_0000);
    run_check("tol_within", 16'h0200, 16'd4, 1, 1'b1, 32'd2, 5, 0);
    gold_src.delete(); gold_src.push_back(32'h0000_0001);
    run_check("tol_over", 16'h0200, 16'd4, 1, 1'b1, 32'd2, 5, 0);
  endtask

  task automatic test_stall();
    load_gold_equal(16'h0100, 16'd4, 8);
    gold_src[3] = 32'h0000_0011;
    gold_src[6] = gold_src[6] ^ 32'h8000_0000;
    stall_mode = 1;
    run_check("stall", 16'h0100, 16'd4, 8, 1'b0, 32'd0, -1, 0);
    stall_mode = 0;
  endtask

  task automatic test_zero_and_wrap();
    gold_src.delete();
    run_check("zero_words", 16'h0040, 16'd4, 0, 1'b0, 32'd0, 2, 0);
    load_gold_equal(16'hFFFC, 16'd8, 2);
    run_check("wrap", 16'hFFFC, 16'd8, 2, 1'b0, 32'd0, 8, 0);
  endtask

  task automatic test_reset_midrun();
    int done_before;
    load_gold_equal(16'h0400, 16'd4, 8);
    gold_src[0] = ~gold_src[0];
    gold_q = gold_src;
    done_before = done_cnt;
    @(posedge clk); #1;
    base_addr = 16'h0400; stride = 16'd4; num_words = 16'd8; mode = 1'b0; tol = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (err_count !== 16'd1 || busy !== 1'b1) begin
      n_err++; $display("FAIL midrun_before_rst: got err=%0d busy=%b required 1/1", err_count, busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if (busy !== 0 || err_count !== '0 || done !== 0 || first_err_addr !== '0) begin
      n_err++; $display("FAIL midrun_after_rst: got busy=%b err=%0d done=%b fa=%h required 0", busy, err_count, done, first_err_addr);
    end
    gold_q.delete();
    repeat (40) @(posedge clk);
    #1;
    n_vec++;
    if (done_cnt !== done_before) begin n_err++; $display("FAIL midrun_no_done: got %0d pulses required 0", done_cnt - done_before); end
    load_gold_equal(16'h0400, 16'd4, 8);
    run_check("after_reset_run", 16'h0400, 16'd4, 8, 1'b0, 32'd0, 26, 0);
  endtask

  task automatic test_start_while_busy();
    load_gold_equal(16'h0300, 16'd4, 4);
    gold_src[2] = gold_src[2] + 32'd5;
    run_check("start_busy", 16'h0300, 16'd4, 4, 1'b0, 32'd0, 14, 4);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      logic [AW-1:0] b, s;
      int            n;
      logic          m;
      logic [DW-1:0] t;
      b = AW'($urandom) & 16'hFFFC;
      case ($urandom_range(0, 3))
        0: s = 16'd0;
        1: s = 16'd4;
        2: s = 16'd8;
        default: s = AW'($urandom) & 16'hFFFC;
      endcase
      n = $urandom_range(1, 12);
      m = 1'($urandom_range(0, 1));
      t = DW'($urandom_range(0, 6));
      for (int i = 0; i < n; i++) glb_mem[int'(AW'(int'(b) + i * int'(s)))] = $urandom;
      load_gold_equal(b, s, n);
      foreach (gold_src[i])
        if ($urandom_range(0, 2) == 0) gold_src[i] = gold_src[i] + DW'($urandom_range(0, 10)) - 32'd5;
      stall_mode = 1'($urandom_range(0, 1));
      run_check($sformatf("random%0d", r), b, s, n, m, t, stall_mode ? -1 : 3 * n + 2, 0);
      stall_mode = 0;
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; stride = '0; num_words = '0;
    mode = 1'b0; tol = '0; glb_rd_data = '0; gold_valid = 1'b0; gold_data = '0;
    test_reset();
    test_exact_pass();
    test_exact_mismatch();
    test_tolerance();
    test_stall();
    test_zero_and_wrap();
    test_reset_midrun();
    test_start_while_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/glb_opsum_checker.md
Name: glb_opsum_checker

Overview:
Synthesizable, parametrised result checker for the one-pass accelerator flow. After the PE array signals done, it walks a strided opsum region of the GLB through a word-wide read port. It compares each word against a golden stream delivered over a valid/ready handshake and reports the error count plus the first mismatch. It generalises the bench-side compare loop with configurable data width, stride, signed tolerance mode and saturating error counting, so regression can run on silicon or FPGA without a simulator.

Parameters:
DATA_W, 32, opsum word width in bits (multiple of 8)
ADDR_W, 16, GLB byte-address width
CNT_W, 16, width of word count and error counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; latches config and begins a check run
base_addr  input  ADDR_W  byte address of first opsum word (word-aligned)
stride  input  ADDR_W  byte step between consecutive checked words (0 legal, re-reads same word)
num_words  input  CNT_W  words to check
mode  input  1  0 = exact compare, 1 = signed tolerance compare
tol  input  DATA_W  non-negative tolerance for mode 1 (unsigned magnitude)
glb_rd_en  output  1  GLB read strobe
glb_rd_addr  output  ADDR_W  GLB byte address
glb_rd_data  input  DATA_W  GLB word, valid exactly one cycle after glb_rd_en
gold_valid  input  1  golden word available
gold_data  input  DATA_W  golden word
gold_ready  output  1  checker consumes gold_data this cycle when gold_valid is also high
busy  output  1  run in progress
done  output  1  one-cycle pulse at run end
pass  output  1  1 when the last run had err_count == 0; held until next start
err_count  output  CNT_W  mismatches in the last run, saturating at 2^CNT_W-1
first_err_addr  output  ADDR_W  GLB byte address of first mismatch
first_err_got  output  DATA_W  GLB value at first mismatch
first_err_exp  output  DATA_W  golden value at first mismatch

Behaviour:
- Reset, synchronous, rst high at a clock edge:
  - state=IDLE.
  - All outputs 0, including pass, err_count and first_err_*.
  - Reset mid-run aborts immediately; no done pulse is issued.
- IDLE:
  - On start, latch base_addr, stride, num_words, mode and tol into internal registers; later changes to these inputs are ignored.
  - Clear err_count, first_err_* and pass.
  - Set busy=1, addr_reg=base_addr, remaining=num_words.
  - If num_words==0, go to FIN; otherwise go to FETCH.
- FETCH (1 cycle): glb_rd_en=1, glb_rd_addr=addr_reg; go to WAIT.
- WAIT (1 cycle): capture glb_rd_data into got_reg; go to CMP.
- CMP:
  - gold_ready=1 only in this state.
  - Holds while gold_valid=0.
  - On gold_valid=1, compare got_reg against gold_data.
- Mismatch rules:
  - mode 0: got != exp.
  - mode 1: |signed(got) - signed(exp)| > tol. The difference is computed at DATA_W+1 bits so it cannot overflow.
- On a mismatch:
  - err_count increments unless it is already all-ones (saturates).
  - If it is the first mismatch of the run, record first_err_addr/got/exp.
- After each compare:
  - addr_reg += stride, modulo 2^ADDR_W (wrap-around permitted).
  - remaining -= 1.
  - If remaining becomes 0, go to FIN; otherwise go to FETCH.
- FIN (1 cycle): done=1, busy=0, pass=(err_count==0); go to IDLE.
- Steady-state throughput: 3 cycles per word with gold_valid held high.
- Latency: start to done = 3*num_words + 2 cycles with gold_valid held high.
- start while busy, or in the FIN cycle, is ignored.
- err_count, pass and first_err_* hold their values in IDLE until the next start.
- glb_rd_en and gold_ready are never high in the same cycle.

Test Plan:
- base=0x100, stride=4, num_words=8, mode 0, GLB equals golden, gold_valid tied 1 -> done pulses at cycle 26 after start, pass=1, err_count=0, glb_rd_addr sequence 0x100..0x11C.
- Same setup, but word 3 in GLB is 0x0000_0010 and golden is 0x0000_0011 -> err_count=1, pass=0, first_err_addr=0x10C, got=0x10, exp=0x11.
- mode 1, tol=2, GLB=0xFFFF_FFFE (-2), golden=0x0000_0000 -> no error. Change golden to 0x0000_0001 (diff 3) -> err_count=1.
- gold_valid toggled 1-0-0-1 pattern -> checker stalls in CMP; each golden word is consumed exactly once; results match the uninterrupted run.
- num_words=0 -> done two cycles after start, pass=1, glb_rd_en never asserted. base=0xFFFC, stride=8, num_words=2 -> second address 0x0004 (wrap).
- rst asserted at cycle 5 of a run -> next cycle busy=0, err_count=0, no done. A fresh start afterwards completes normally. A start pulsed while busy is ignored (config unchanged).
